// File: rtl/vblank_update_sched_if.sv
// -----------------------------------------------------------------------------
// vblank_update_sched_if
//   Handshake between the spectrum writer and the vertical-blanking update
//   scheduler.
//
//   upd_req      writer -> scheduler  request, held high while the writer wants
//                                     access to the bar-height memory
//   upd_done     writer -> scheduler  one-cycle completion pulse
//   upd_gnt      scheduler -> writer  write grant (level)
//   upd_overrun  scheduler -> writer  one-cycle pulse when a grant is revoked
//                                     because the update window closed
//   overrun_cnt  scheduler -> writer  saturating count of revoked grants
//
//   master: the writer side.  slave: the scheduler side.
// -----------------------------------------------------------------------------
interface vblank_update_sched_if;
    logic       upd_req;
    logic       upd_done;
    logic       upd_gnt;
    logic       upd_overrun;
    logic [7:0] overrun_cnt;

    modport master (
        output upd_req,
        output upd_done,
        input  upd_gnt,
        input  upd_overrun,
        input  overrun_cnt
    );

    modport slave (
        input  upd_req,
        input  upd_done,
        output upd_gnt,
        output upd_overrun,
        output overrun_cnt
    );
endinterface

// File: rtl/vblank_update_sched.sv
// -----------------------------------------------------------------------------
// vblank_update_sched
//   Single-clock video timing generator plus the arbiter that lets the spectrum
//   writer update the bar-height memory only during vertical blanking, so a
//   displayed frame is never torn.
//
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   hpos, vpos   current pixel column / line
//   hsync, vsync active-low sync pulses, aligned with hpos/vpos
//   disp_active  high inside the visible area
//   frame_start  one-cycle pulse while hpos=0, vpos=0
//   upd          writer handshake (see vblank_update_sched_if)
// -----------------------------------------------------------------------------
module vblank_update_sched #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FRONT     = 56,
    parameter int H_SYNC      = 120,
    parameter int H_TOTAL     = 1040,
    parameter int V_ACTIVE    = 600,
    parameter int V_FRONT     = 37,
    parameter int V_SYNC      = 6,
    parameter int V_TOTAL     = 666,
    parameter int GUARD_LINES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [10:0]           hpos,
    output logic [10:0]           vpos,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  disp_active,
    output logic                  frame_start,
    vblank_update_sched_if.slave  upd
);

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [10:0] WIN_END = 11'(V_TOTAL - GUARD_LINES);

    typedef enum logic [1:0] {IDLE, PEND, GRANT, RELEASE} state_t;

    state_t      state, state_nxt;
    logic        run;
    logic [10:0] h_nxt, v_nxt;
    logic        in_window;
    logic        ovr_nxt;

    // ---- next-count decode ----
    // 'run' holds the counters at 0,0 for the first edge after reset, so the
    // registered decodes (frame_start in particular) line up with the 0,0
    // position on the very first cycle out of reset.
    always_comb begin
        h_nxt = 11'd0;
        v_nxt = 11'd0;
        if (run) begin
            v_nxt = vpos;
            if (hpos == H_LAST) begin
                v_nxt = (vpos == V_LAST) ? 11'd0 : vpos + 11'd1;
            end else begin
                h_nxt = hpos + 11'd1;
            end
        end
    end

    // ---- timing registers: outputs decoded from next-count values ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            hpos        <= 11'd0;
            vpos        <= 11'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            disp_active <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            hsync       <= !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
            vsync       <= !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
            disp_active <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            frame_start <= (h_nxt == 11'd0) && (v_nxt == 11'd0);
        end
    end

    // Update window: vertical blanking minus a guard band before frame wrap,
    // so the writer has finished before the first visible line is fetched.
    assign in_window = (vpos >= V_ACT) && (vpos < WIN_END);

    // ---- grant FSM: next state ----
    always_comb begin
        state_nxt = state;
        ovr_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (upd.upd_req) state_nxt = in_window ? GRANT : PEND;
            end
            PEND: begin
                if (!upd.upd_req)  state_nxt = IDLE;
                else if (in_window) state_nxt = GRANT;
            end
            GRANT: begin
                // Completion (or withdrawn request) wins over a window close
                // in the same cycle; only an unfinished grant is an overrun.
                if (upd.upd_done || !upd.upd_req) begin
                    state_nxt = RELEASE;
                end else if (!in_window) begin
                    state_nxt = RELEASE;
                    ovr_nxt   = 1'b1;
                end
            end
            RELEASE: begin
                // Wait for the request to drop: one grant per request.
                if (!upd.upd_req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- grant FSM: registered state and outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            upd.upd_gnt     <= 1'b0;
            upd.upd_overrun <= 1'b0;
            upd.overrun_cnt <= 8'd0;
        end else begin
            state           <= state_nxt;
            upd.upd_gnt     <= (state_nxt == GRANT);
            upd.upd_overrun <= ovr_nxt;
            if (ovr_nxt && (upd.overrun_cnt != 8'hFF)) begin
                upd.overrun_cnt <= upd.overrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vblank_update_sched.sv
// -----------------------------------------------------------------------------
// tb_vblank_update_sched
//   Bench for vblank_update_sched using a reduced timing set so that full
//   frames and the overrun-saturation sequence fit in a short run:
//     line  = 16 pixels (8 active, 2 front, 3 sync)
//     frame = 12 lines  (6 active, 1 front, 2 sync), guard 2
//   so the update window is lines 6..9 and vsync is low on lines 7..8.
//   Grant edges and overrun pulses are checked against a scoreboard of
//   expected (kind, hpos, vpos) events queued when stimulus is driven.
// -----------------------------------------------------------------------------
module tb_vblank_update_sched;

    localparam int HA = 8, HF = 2, HS = 3, HT = 16;
    localparam int VA = 6, VF = 1, VS = 2, VT = 12, GL = 2;
    localparam int FRAME   = HT * VT;
    localparam int WIN_END = VT - GL;
    localparam int EV_RISE = 1, EV_FALL = 2, EV_OVR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hpos, vpos;
    logic        hsync, vsync, disp_active, frame_start;

    vblank_update_sched_if u_if ();

    vblank_update_sched #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT),
        .GUARD_LINES(GL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hpos        (hpos),
        .vpos        (vpos),
        .hsync       (hsync),
        .vsync       (vsync),
        .disp_active (disp_active),
        .frame_start (frame_start),
        .upd         (u_if)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int kind;
        int h;
        int v;
    } ev_t;

    ev_t exp_q[$];

    task automatic expect_ev(input int kind, input int h, input int v);
        ev_t e;
        e.kind = kind;
        e.h    = h;
        e.v    = v;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", kind, 0);
            return;
        end
        e = exp_q.pop_front();
        check("sb_kind", kind, e.kind);
        check("sb_hpos", int'(hpos), e.h);
        check("sb_vpos", int'(vpos), e.v);
    endtask

    // Event monitor: grant edges and overrun pulses, sampled mid-cycle.
    logic gnt_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            gnt_prev <= 1'b0;
        end else begin
            if (u_if.upd_gnt && !gnt_prev) match_ev(EV_RISE);
            if (!u_if.upd_gnt && gnt_prev) match_ev(EV_FALL);
            if (u_if.upd_overrun)          match_ev(EV_OVR);
            gnt_prev <= u_if.upd_gnt;
        end
    end

    // Step on negedges until the DUT shows (v, h), bounded.
    task automatic wait_pos(input int v, input int h);
        int n;
        n = 0;
        while (!(int'(vpos) == v && int'(hpos) == h)) begin
            @(negedge clk);
            n++;
            if (n > 3 * FRAME) begin
                check("wait_pos_timeout", int'(vpos) * 100 + int'(hpos), v * 100 + h);
                return;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int pos_err, hs_err, hs_low, vs_err, vs_low, da_err, da_cnt, fs_cnt, fs_at;
    int eh, ev;
    logic hs_exp, vs_exp, da_exp;

    initial begin
        u_if.upd_req  = 1'b0;
        u_if.upd_done = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_hpos",        int'(hpos), 0);
        check("rst_vpos",        int'(vpos), 0);
        check("rst_hsync",       int'(hsync), 1);
        check("rst_vsync",       int'(vsync), 1);
        check("rst_disp_active", int'(disp_active), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_gnt",         int'(u_if.upd_gnt), 0);
        check("rst_overrun",     int'(u_if.upd_overrun), 0);
        check("rst_ovr_cnt",     int'(u_if.overrun_cnt), 0);

        // Full frame from reset release: cycle i sits at (i%HT, i/HT)
        rst_n = 1'b1;
        @(negedge clk);
        pos_err = 0; hs_err = 0; hs_low = 0; vs_err = 0; vs_low = 0;
        da_err = 0; da_cnt = 0; fs_cnt = 0; fs_at = -1;
        for (int i = 0; i < FRAME; i++) begin
            eh = i % HT;
            ev = i / HT;
            hs_exp = !(eh >= HA + HF && eh < HA + HF + HS);
            vs_exp = !(ev >= VA + VF && ev < VA + VF + VS);
            da_exp = (eh < HA) && (ev < VA);
            if (int'(hpos) != eh || int'(vpos) != ev) pos_err++;
            if (frame_start) begin fs_cnt++; fs_at = i; end
            if (!hsync) hs_low++;
            if (hsync !== hs_exp) hs_err++;
            if (!vsync) vs_low++;
            if (vsync !== vs_exp) vs_err++;
            if (disp_active) da_cnt++;
            if (disp_active !== da_exp) da_err++;
            @(negedge clk);
        end
        check("frame_pos_errors",   pos_err, 0);
        check("frame_start_count",  fs_cnt, 1);
        check("frame_start_cycle",  fs_at, 0);
        check("hsync_low_cycles",   hs_low, HS * VT);
        check("hsync_placement",    hs_err, 0);
        check("vsync_low_cycles",   vs_low, VS * HT);
        check("vsync_placement",    vs_err, 0);
        check("disp_active_cycles", da_cnt, HA * VA);
        check("disp_active_place",  da_err, 0);
        check("wrap_frame_start",   int'(frame_start), 1);
        check("wrap_hpos",          int'(hpos), 0);
        check("wrap_vpos",          int'(vpos), 0);

        // Request before the window: pending, then granted at window start
        wait_pos(1, 0);
        u_if.upd_req = 1'b1;
        expect_ev(EV_RISE, 1, VA);
        wait_pos(VA - 1, HT - 1);
        check("pend_gnt_before_win", int'(u_if.upd_gnt), 0);
        @(negedge clk);
        check("pend_gnt_win_first", int'(u_if.upd_gnt), 0);
        @(negedge clk);
        check("pend_gnt_rise", int'(u_if.upd_gnt), 1);
        wait_pos(VA + 1, 0);
        u_if.upd_done = 1'b1;
        expect_ev(EV_FALL, 1, VA + 1);
        @(negedge clk);
        u_if.upd_done = 1'b0;
        u_if.upd_req  = 1'b0;
        check("pend_done_gnt", int'(u_if.upd_gnt), 0);
        check("pend_ovr_cnt",  int'(u_if.overrun_cnt), 0);

        // Request inside window, never completed: revoked at window close
        wait_pos(VA + 2, 0);
        u_if.upd_req = 1'b1;
        expect_ev(EV_RISE, 1, VA + 2);
        expect_ev(EV_FALL, 1, WIN_END);
        expect_ev(EV_OVR,  1, WIN_END);
        wait_pos(WIN_END, 2);
        check("ovr_cnt_one", int'(u_if.overrun_cnt), 1);
        // Held request gets no second grant, even through the next window
        wait_pos(VA + 2, 5);
        check("release_hold_gnt", int'(u_if.upd_gnt), 0);
        u_if.upd_req = 1'b0;
        @(negedge clk);
        // Stray done while idle is ignored
        u_if.upd_done = 1'b1;
        @(negedge clk);
        u_if.upd_done = 1'b0;

        // Done coincident with window close: normal completion
        wait_pos(VA + 1, 0);
        u_if.upd_req = 1'b1;
        expect_ev(EV_RISE, 1, VA + 1);
        wait_pos(WIN_END, 0);
        u_if.upd_done = 1'b1;
        expect_ev(EV_FALL, 1, WIN_END);
        @(negedge clk);
        u_if.upd_done = 1'b0;
        u_if.upd_req  = 1'b0;
        @(negedge clk);
        check("coincident_ovr_cnt", int'(u_if.overrun_cnt), 1);

        // Repeated overruns: counter saturates at 255
        for (int k = 0; k < 260; k++) begin
            wait_pos(VA + 2, 0);
            u_if.upd_req = 1'b1;
            expect_ev(EV_RISE, 1, VA + 2);
            expect_ev(EV_FALL, 1, WIN_END);
            expect_ev(EV_OVR,  1, WIN_END);
            wait_pos(WIN_END, 2);
            u_if.upd_req = 1'b0;
            if (k == 252) check("ovr_cnt_254", int'(u_if.overrun_cnt), 254);
            if (k == 253) check("ovr_cnt_255", int'(u_if.overrun_cnt), 255);
        end
        check("ovr_cnt_saturated", int'(u_if.overrun_cnt), 255);

        // Reset in the middle of a grant
        wait_pos(VA + 2, 0);
        u_if.upd_req = 1'b1;
        expect_ev(EV_RISE, 1, VA + 2);
        wait_pos(VA + 2, 5);
        check("pre_rst_gnt",   int'(u_if.upd_gnt), 1);
        check("pre_rst_vsync", int'(vsync), 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt",     int'(u_if.upd_gnt), 0);
        check("async_rst_hpos",    int'(hpos), 0);
        check("async_rst_vpos",    int'(vpos), 0);
        check("async_rst_hsync",   int'(hsync), 1);
        check("async_rst_vsync",   int'(vsync), 1);
        check("async_rst_ovr_cnt", int'(u_if.overrun_cnt), 0);
        u_if.upd_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_frame_start", int'(frame_start), 1);
        check("post_rst_hpos",        int'(hpos), 0);
        check("post_rst_vpos",        int'(vpos), 0);
        @(negedge clk);
        check("post_rst_fs_low",      int'(frame_start), 0);
        check("post_rst_hpos_step",   int'(hpos), 1);

        repeat (4) @(negedge clk);
        check("sb_pending_events", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
